// File: rtl/qpu_instr_encoder.sv
// Packs field bundles into 32-bit QPU instruction words, tags each with a byte address and queues them in a small FIFO.
// Optional QPU_ENC_IMM_RANGE_CHK_EN rejects immediates that do not fit the signed field width of their kind.
module qpu_instr_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 16,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_kind,
    input  logic [2:0]           in_func3,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    input  logic [8:0]           in_qop1,
    input  logic [8:0]           in_qop2,
    input  logic [2:0]           in_pi,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 enc_err,
    output logic [ERR_CNT_W-1:0] enc_err_cnt,
    output logic                 busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] K_LOAD    = 4'd0;
    localparam logic [3:0] K_STORE   = 4'd1;
    localparam logic [3:0] K_BRANCH  = 4'd2;
    localparam logic [3:0] K_OP_IMM  = 4'd3;
    localparam logic [3:0] K_OP      = 4'd4;
    localparam logic [3:0] K_QWAIT   = 4'd5;
    localparam logic [3:0] K_FMR     = 4'd6;
    localparam logic [3:0] K_SMIS    = 4'd7;
    localparam logic [3:0] K_QUANTUM = 4'd8;

    logic [31:0]          word_d;
    logic                 legal_d;
    logic                 imm_ok_d;
    logic [31:0]          instr_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]    addr_mem_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 enc_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 full, accept, push, pop;
    logic                 base_lsb_unused;

    assign base_lsb_unused = ^cfg_base_addr[1:0];

`ifdef QPU_ENC_IMM_RANGE_CHK_EN
    logic fit14, fit17, fit22, fit27;
    assign fit14 = (&in_imm[31:13]) | ~(|in_imm[31:13]);
    assign fit17 = (&in_imm[31:16]) | ~(|in_imm[31:16]);
    assign fit22 = (&in_imm[31:21]) | ~(|in_imm[31:21]);
    assign fit27 = (&in_imm[31:26]) | ~(|in_imm[31:26]);
`else
    logic imm_hi_unused;
    assign imm_hi_unused = ^in_imm[31:27];
`endif

    // Classical base word first; immediate slices then overwrite the fields they share.
    always_comb begin
        word_d   = {in_func3, in_rs2, 9'd0, in_rs1, in_rd, 5'd0};
        legal_d  = 1'b1;
        imm_ok_d = 1'b1;
        case (in_kind)
            K_LOAD: begin
                word_d[31:29] = in_imm[16:14];
                word_d[28:15] = in_imm[13:0];
`ifdef QPU_ENC_IMM_RANGE_CHK_EN
                imm_ok_d = fit17;
`endif
            end
            K_STORE: begin
                word_d[4:0]   = 5'b01000;
                word_d[31:29] = in_imm[16:14];
                word_d[9:5]   = in_imm[13:9];
                word_d[23:15] = in_imm[8:0];
`ifdef QPU_ENC_IMM_RANGE_CHK_EN
                imm_ok_d = fit17;
`endif
            end
            K_BRANCH: begin
                word_d[4:0]   = 5'b11000;
                word_d[9:5]   = in_imm[13:9];
                word_d[23:15] = in_imm[8:0];
`ifdef QPU_ENC_IMM_RANGE_CHK_EN
                imm_ok_d = fit14;
`endif
            end
            K_OP_IMM: begin
                word_d[4:0]   = 5'b00010;
                word_d[28:15] = in_imm[13:0];
`ifdef QPU_ENC_IMM_RANGE_CHK_EN
                imm_ok_d = fit14;
`endif
            end
            K_OP:  word_d[4:0] = 5'b01010;
            K_FMR: word_d[4:0] = 5'b11010;
            K_QWAIT: begin
                word_d[4:0]   = 5'b10010;
                word_d[31:29] = in_imm[26:24];
                word_d[9:5]   = in_imm[23:19];
                word_d[28:24] = in_imm[18:14];
                word_d[14:10] = in_imm[13:9];
                word_d[23:15] = in_imm[8:0];
`ifdef QPU_ENC_IMM_RANGE_CHK_EN
                imm_ok_d = fit27;
`endif
            end
            K_SMIS: begin
                word_d[4:0]   = 5'b00110;
                word_d[31:24] = in_imm[21:14];
                word_d[14:10] = in_imm[13:9];
                word_d[23:15] = in_imm[8:0];
`ifdef QPU_ENC_IMM_RANGE_CHK_EN
                imm_ok_d = fit22;
`endif
            end
            K_QUANTUM: word_d = {in_pi, in_rs2, in_qop2, in_rs1, in_qop1, 1'b1};
            default:   legal_d = 1'b0;
        endcase
        legal_d = legal_d & imm_ok_d;
    end

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign in_ready  = ~cfg_load & (~full | out_ready);
    assign accept    = in_valid & in_ready;
    assign push      = accept & legal_d;
    assign out_valid = (count_q != '0);
    assign busy      = out_valid;
    assign pop       = out_valid & out_ready;
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_addr  = addr_mem_q[rd_ptr_q];
    assign enc_err     = enc_err_q;
    assign enc_err_cnt = err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                addr_mem_q[i]  <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            enc_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            enc_err_q <= accept & ~legal_d;
            if (accept && !legal_d && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + 1'b1;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= word_d;
                addr_mem_q[wr_ptr_q]  <= addr_q;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // cfg_load forces in_ready low, so it can never coincide with a push.
            if (cfg_load)
                addr_q <= {cfg_base_addr[ADDR_W-1:2], 2'b00};
            else if (push)
                addr_q <= addr_q + ADDR_W'(4);
        end
    end
endmodule

// File: tb/tb_qpu_instr_encoder.sv
// Directed and randomized bench for qpu_instr_encoder against a field-placement reference model and a word scoreboard.
module tb_qpu_instr_encoder;
    localparam int DEPTH = 2;

    logic        clk, rst_n, cfg_load, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] cfg_base_addr, out_addr;
    logic [3:0]  in_kind;
    logic [2:0]  in_func3, in_pi;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr;
    logic [8:0]  in_qop1, in_qop2;
    logic        enc_err, busy;
    logic [7:0]  enc_err_cnt;

    qpu_instr_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(16), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_base_addr(cfg_base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_func3(in_func3),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_qop1(in_qop1), .in_qop2(in_qop2), .in_pi(in_pi),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .enc_err(enc_err), .enc_err_cnt(enc_err_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] addr;
    } ent_t;

    ent_t        sb_q[$];
    logic [15:0] m_addr;
    logic        m_err;
    int          m_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] w, input longint v, input int pos, input int width);
        longint mask, ww;
        mask = (longint'(1) << width) - 1;
        ww   = longint'(w);
        ww   = (ww & ~(mask << pos)) | ((v & mask) << pos);
        return ww[31:0];
    endfunction

    // Returns {legal, word} for one field bundle, built from the field placement table.
    function automatic logic [32:0] ref_encode(input int kind, input int f3, input int rd, input int rs1,
                                               input int rs2, input logic [31:0] imm, input int q1,
                                               input int q2, input int pi);
        int     opc_tab[9] = '{0, 8, 24, 2, 10, 18, 26, 6, 0};
        int     width_tab[9] = '{17, 17, 14, 14, 0, 27, 0, 22, 0};
        longint u, s, w;
        logic [31:0] word;
        logic   legal;
        u = longint'(imm);
        s = longint'($signed(imm));
        if (kind > 8) return {1'b0, 32'h0};
        legal = 1'b1;
        if (kind == 8) begin
            w = (longint'(pi) << 29) + (longint'(rs2) << 24) + (longint'(q2) << 15)
              + (longint'(rs1) << 10) + (longint'(q1) << 1) + 1;
            return {1'b1, w[31:0]};
        end
        w = (longint'(f3) << 29) + (longint'(rs2) << 24) + (longint'(rs1) << 10)
          + (longint'(rd) << 5) + longint'(opc_tab[kind]);
        word = w[31:0];
        case (kind)
            0: begin word = ins(word, u >> 14, 29, 3); word = ins(word, u, 15, 14); end
            1: begin word = ins(word, u >> 14, 29, 3); word = ins(word, u >> 9, 5, 5);
                     word = ins(word, u, 15, 9); end
            2: begin word = ins(word, u >> 9, 5, 5); word = ins(word, u, 15, 9); end
            3: word = ins(word, u, 15, 14);
            5: begin word = ins(word, u >> 24, 29, 3); word = ins(word, u >> 19, 5, 5);
                     word = ins(word, u >> 14, 24, 5); word = ins(word, u >> 9, 10, 5);
                     word = ins(word, u, 15, 9); end
            7: begin word = ins(word, u >> 14, 24, 8); word = ins(word, u >> 9, 10, 5);
                     word = ins(word, u, 15, 9); end
            default: ;
        endcase
`ifdef QPU_ENC_IMM_RANGE_CHK_EN
        if (width_tab[kind] != 0) begin
            longint lim;
            lim = longint'(1) << (width_tab[kind] - 1);
            if (s < -lim || s >= lim) legal = 1'b0;
        end
`else
        if (width_tab[kind] < 0 || s < 0) legal = legal;
`endif
        return {legal, word};
    endfunction

    // Called at a falling edge with inputs settled: check outputs, then advance the model across the rising edge.
    task automatic cycle();
        logic        exp_ready;
        logic [32:0] r;
        ent_t        e;
        #1;
        exp_ready = !cfg_load && (sb_q.size() < DEPTH || out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
        chk("busy", {31'd0, busy}, {31'd0, sb_q.size() != 0});
        if (sb_q.size() != 0) begin
            chk("out_instr", out_instr, sb_q[0].instr);
            chk("out_addr", {16'd0, out_addr}, {16'd0, sb_q[0].addr});
        end
        chk("enc_err", {31'd0, enc_err}, {31'd0, m_err});
        chk("enc_err_cnt", {24'd0, enc_err_cnt}, m_cnt);
        @(posedge clk);
        m_err = 1'b0;
        if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
        if (cfg_load) begin
            m_addr = {cfg_base_addr[15:2], 2'b00};
        end else if (in_valid && exp_ready) begin
            r = ref_encode(int'(in_kind), int'(in_func3), int'(in_rd), int'(in_rs1), int'(in_rs2),
                           in_imm, int'(in_qop1), int'(in_qop2), int'(in_pi));
            if (r[32]) begin
                e.instr = r[31:0];
                e.addr  = m_addr;
                sb_q.push_back(e);
                m_addr = m_addr + 16'd4;
            end else begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_bundle(input int kind, input int f3, input int rd, input int rs1, input int rs2,
                              input logic [31:0] imm, input int q1, input int q2, input int pi);
        in_kind  = kind[3:0];
        in_func3 = f3[2:0];
        in_rd    = rd[4:0];
        in_rs1   = rs1[4:0];
        in_rs2   = rs2[4:0];
        in_imm   = imm;
        in_qop1  = q1[8:0];
        in_qop2  = q2[8:0];
        in_pi    = pi[2:0];
        in_valid = 1'b1;
    endtask

    task automatic send(input int kind, input int f3, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input int q1, input int q2, input int pi);
        set_bundle(kind, f3, rd, rs1, rs2, imm, q1, q2, pi);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_addr = 16'd0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    initial begin
        int w, kind;
        logic [31:0] imm;
        rst_n = 1'b0; cfg_load = 1'b0; cfg_base_addr = 16'd0; out_ready = 1'b0;
        set_bundle(0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
        in_valid = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", {16'd0, out_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, enc_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, enc_err_cnt}, 32'd0);
        rst_n = 1'b1;

        // OP_IMM with negative immediate, one-cycle latency into an empty FIFO
        send(3, 0, 3, 1, 0, -32'sd5, 0, 0, 0);
        chk("opimm_word", out_instr, 32'h1FFD8462);
        chk("opimm_addr", {16'd0, out_addr}, 32'h0);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        send(8, 0, 0, 2, 0, 32'd0, 9'h1FF, 0, 1);
        chk("quantum_word", out_instr, 32'h20000BFF);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // base load blocks a pending bundle in the same cycle
        set_bundle(4, 1, 2, 3, 4, 32'd0, 0, 0, 0);
        cfg_load = 1'b1; cfg_base_addr = 16'h0103;
        cycle();
        cfg_load = 1'b0; in_valid = 1'b0;
        send(5, 0, 0, 0, 0, 32'd100, 0, 0, 0);
        chk("qwait_word", out_instr, 32'h00320012);
        chk("qwait_addr", {16'd0, out_addr}, 32'h0100);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        send(4, 1, 2, 3, 4, 32'd0, 0, 0, 0);
        chk("next_addr", {16'd0, out_addr}, 32'h0104);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        send(3, 0, 0, 0, 0, 32'd8192, 0, 0, 0);
`ifdef QPU_ENC_IMM_RANGE_CHK_EN
        chk("range_err", {31'd0, enc_err}, 32'd1);
        chk("range_cnt", {24'd0, enc_err_cnt}, 32'd1);
        chk("range_nopush", {31'd0, out_valid}, 32'd0);
`else
        chk("trunc_word", out_instr, 32'h10000002);
        chk("trunc_addr", {16'd0, out_addr}, 32'h0108);
`endif
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // back-pressure: third bundle waits until the consumer drains
        cfg_load = 1'b1; cfg_base_addr = 16'h0200; cycle(); cfg_load = 1'b0;
        send(4, 1, 1, 1, 1, 32'd0, 0, 0, 0);
        send(6, 2, 2, 2, 2, 32'd0, 0, 0, 0);
        set_bundle(0, 3, 3, 3, 3, 32'd77, 0, 0, 0);
        cycle();
        chk("full_ready_low", {31'd0, in_ready}, 32'd0);
        chk("full_head", {16'd0, out_addr}, 32'h0200);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("order_2", {16'd0, out_addr}, 32'h0204);
        cycle();
        chk("order_3", {16'd0, out_addr}, 32'h0208);
        cycle(); cycle();
        out_ready = 1'b0;

        send(12, 0, 0, 0, 0, 32'd0, 0, 0, 0);
        chk("illegal_err", {31'd0, enc_err}, 32'd1);

        // asynchronous reset with two words queued
        send(4, 0, 1, 1, 1, 32'd0, 0, 0, 0);
        send(8, 0, 1, 1, 1, 32'd0, 3, 4, 5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_err_cnt", {24'd0, enc_err_cnt}, 32'd0);
        chk("arst_out_addr", {16'd0, out_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // error counter saturation
        out_ready = 1'b1;
        set_bundle(15, 0, 0, 0, 0, 32'd0, 0, 0, 0);
        repeat (260) cycle();
        in_valid = 1'b0;
        cycle();
        chk("err_sat", {24'd0, enc_err_cnt}, 32'd255);

        for (int i = 0; i < 600; i++) begin
            kind = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 8)) : int'($urandom_range(9, 15));
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = $urandom_range(0, 127) - 32'd64;
                default: begin
                    case ($urandom_range(0, 3))
                        0: w = 14; 1: w = 17; 2: w = 22; default: w = 27;
                    endcase
                    imm = (32'd1 << (w - 1)) - 32'($urandom_range(0, 1));
                    if ($urandom_range(0, 1) == 1) imm = -imm - 32'($urandom_range(0, 1));
                end
            endcase
            set_bundle(kind, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm,
                       int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                       int'($urandom_range(0, 7)));
            in_valid      = ($urandom_range(0, 9) < 7);
            out_ready     = ($urandom_range(0, 9) < 6);
            cfg_load      = ($urandom_range(0, 19) == 0);
            cfg_base_addr = 16'($urandom);
            cycle();
        end
        in_valid = 1'b0; cfg_load = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
